// File: rtl/regfile_dp.sv
// rtl/regfile_dp.sv - two-write, two-read register file with registered, optionally write-first reads
module regfile_dp #(
   parameter int DATA_W = 16,
   parameter int IN_W   = 4,
   parameter int NREGS  = 8,
   parameter int ADDR_W = $clog2(NREGS),
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] waddr_a,
   input  logic [IN_W-1:0]   wdata_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] waddr_b,
   input  logic [IN_W-1:0]   wdata_b,
   input  logic              sext,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   output logic              collision,
   output logic              addr_err
);

   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] ext_a, ext_b;
   logic [DATA_W-1:0] nxt_a, nxt_b;
   logic              wa_in, wb_in, ra_in, rb_in;
   logic              wr_a, wr_b;
   logic              collision_d, addr_err_d;

   generate
      if (IN_W == DATA_W) begin : g_noext
         assign ext_a = wdata_a;
         assign ext_b = wdata_b;
      end else begin : g_ext
         // sext gates the replicated sign bit, so one expression covers both extensions
         assign ext_a = {{(DATA_W-IN_W){sext & wdata_a[IN_W-1]}}, wdata_a};
         assign ext_b = {{(DATA_W-IN_W){sext & wdata_b[IN_W-1]}}, wdata_b};
      end
   endgenerate

   generate
      if (NREGS == (1 << ADDR_W)) begin : g_full
         assign wa_in = 1'b1;
         assign wb_in = 1'b1;
         assign ra_in = 1'b1;
         assign rb_in = 1'b1;
      end else begin : g_part
         localparam logic [ADDR_W:0] NREGS_L = (ADDR_W+1)'(NREGS);
         assign wa_in = {1'b0, waddr_a} < NREGS_L;
         assign wb_in = {1'b0, waddr_b} < NREGS_L;
         assign ra_in = {1'b0, raddr_a} < NREGS_L;
         assign rb_in = {1'b0, raddr_b} < NREGS_L;
      end
   endgenerate

   assign wr_a = we_a & wa_in;
   assign wr_b = we_b & wb_in;

   assign collision_d = wr_a & wr_b & (waddr_a == waddr_b);
   assign addr_err_d  = (we_a & ~wa_in) | (we_b & ~wb_in) | ~ra_in | ~rb_in;

   // port B is checked first so it wins a same-address collision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (wr_b && (waddr_b == ADDR_W'(i))) begin
               regs[i] <= ext_b;
            end else if (wr_a && (waddr_a == ADDR_W'(i))) begin
               regs[i] <= ext_a;
            end
         end
      end
   end

   // an out-of-range address matches no register and reads as zero
   always_comb begin
      nxt_a = '0;
      nxt_b = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (raddr_a == ADDR_W'(i)) begin
            nxt_a = regs[i];
         end
         if (raddr_b == ADDR_W'(i)) begin
            nxt_b = regs[i];
         end
      end
      if (BYPASS) begin
         if (wr_b && (waddr_b == raddr_a)) begin
            nxt_a = ext_b;
         end else if (wr_a && (waddr_a == raddr_a)) begin
            nxt_a = ext_a;
         end
         if (wr_b && (waddr_b == raddr_b)) begin
            nxt_b = ext_b;
         end else if (wr_a && (waddr_a == raddr_b)) begin
            nxt_b = ext_a;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_a   <= '0;
         rdata_b   <= '0;
         collision <= 1'b0;
         addr_err  <= 1'b0;
      end else begin
         rdata_a   <= nxt_a;
         rdata_b   <= nxt_b;
         collision <= collision_d;
         addr_err  <= addr_err_d;
      end
   end

endmodule

// File: tb/tb_regfile_dp.sv
// tb/tb_regfile_dp.sv - table and scoreboard bench for regfile_dp (write-first, read-first, 6-entry)
module tb_regfile_dp;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        we_a, we_b, sext;
   logic [2:0]  waddr_a, waddr_b, raddr_a, raddr_b;
   logic [3:0]  wdata_a, wdata_b;
   logic [15:0] rda [3];
   logic [15:0] rdb [3];
   logic        coll [3];
   logic        err [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_dp #(.DATA_W(16), .IN_W(4), .NREGS(8), .BYPASS(1'b1)) dut_wf (
      .clk(clk), .rst(rst),
      .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
      .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
      .sext(sext), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(rda[0]), .rdata_b(rdb[0]), .collision(coll[0]), .addr_err(err[0])
   );

   regfile_dp #(.DATA_W(16), .IN_W(4), .NREGS(8), .BYPASS(1'b0)) dut_rf (
      .clk(clk), .rst(rst),
      .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
      .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
      .sext(sext), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(rda[1]), .rdata_b(rdb[1]), .collision(coll[1]), .addr_err(err[1])
   );

   regfile_dp #(.DATA_W(16), .IN_W(4), .NREGS(6), .BYPASS(1'b1)) dut_oor (
      .clk(clk), .rst(rst),
      .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
      .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
      .sext(sext), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(rda[2]), .rdata_b(rdb[2]), .collision(coll[2]), .addr_err(err[2])
   );

   // en bits: [3] rdata_a, [2] rdata_b, [1] collision, [0] addr_err
   typedef struct {
      string       tag;
      int          inst;
      logic [3:0]  en;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        c;
      logic        e;
   } exp_t;

   typedef struct {
      logic        we_a;
      logic [2:0]  waddr_a;
      logic [3:0]  wdata_a;
      logic        we_b;
      logic [2:0]  waddr_b;
      logic [3:0]  wdata_b;
      logic        sext;
      logic [2:0]  raddr_a;
      logic [2:0]  raddr_b;
      logic [15:0] ea;
      logic [15:0] eb;
      logic        ec;
      logic        ee;
   } vec_t;

   exp_t sbq[$];
   vec_t vt[12];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_inst(input exp_t e);
      if (e.en[3]) check($sformatf("%s inst%0d rdata_a", e.tag, e.inst), rda[e.inst], e.ra);
      if (e.en[2]) check($sformatf("%s inst%0d rdata_b", e.tag, e.inst), rdb[e.inst], e.rb);
      if (e.en[1]) check($sformatf("%s inst%0d collision", e.tag, e.inst), 16'(coll[e.inst]), 16'(e.c));
      if (e.en[0]) check($sformatf("%s inst%0d addr_err", e.tag, e.inst), 16'(err[e.inst]), 16'(e.e));
   endtask

   task automatic expect_out(input string tag, input int inst, input logic [3:0] en,
                             input logic [15:0] ra, input logic [15:0] rb,
                             input logic c, input logic e);
      exp_t x;
      x.tag = tag; x.inst = inst; x.en = en;
      x.ra = ra; x.rb = rb; x.c = c; x.e = e;
      sbq.push_back(x);
   endtask

   task automatic tick();
      exp_t x;
      @(posedge clk);
      #1;
      while (sbq.size() > 0) begin
         x = sbq.pop_front();
         check_inst(x);
      end
   endtask

   task automatic set_in(input logic wea, input logic [2:0] wa, input logic [3:0] da,
                         input logic web, input logic [2:0] wb, input logic [3:0] db,
                         input logic sx, input logic [2:0] ra, input logic [2:0] rb);
      we_a = wea; waddr_a = wa; wdata_a = da;
      we_b = web; waddr_b = wb; wdata_b = db;
      sext = sx; raddr_a = ra; raddr_b = rb;
   endtask

   initial begin
      exp_t z;
      // fields: we_a waddr_a wdata_a we_b waddr_b wdata_b sext raddr_a raddr_b | rdata_a rdata_b collision addr_err
      vt[0]  = '{1'b1, 3'd3, 4'hA, 1'b0, 3'd0, 4'h0, 1'b1, 3'd3, 3'd0, 16'hFFFA, 16'h0000, 1'b0, 1'b0};
      vt[1]  = '{1'b0, 3'd0, 4'h0, 1'b1, 3'd4, 4'hA, 1'b0, 3'd4, 3'd3, 16'h000A, 16'hFFFA, 1'b0, 1'b0};
      vt[2]  = '{1'b1, 3'd5, 4'h7, 1'b0, 3'd0, 4'h0, 1'b1, 3'd5, 3'd4, 16'h0007, 16'h000A, 1'b0, 1'b0};
      vt[3]  = '{1'b1, 3'd2, 4'h1, 1'b1, 3'd2, 4'h6, 1'b0, 3'd2, 3'd3, 16'h0006, 16'hFFFA, 1'b1, 1'b0};
      vt[4]  = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd2, 3'd2, 16'h0006, 16'h0006, 1'b0, 1'b0};
      vt[5]  = '{1'b1, 3'd1, 4'h1, 1'b1, 3'd6, 4'h6, 1'b0, 3'd1, 3'd6, 16'h0001, 16'h0006, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 3'd7, 4'h9, 1'b0, 3'd0, 4'h0, 1'b0, 3'd7, 3'd0, 16'h0009, 16'h0000, 1'b0, 1'b0};
      vt[7]  = '{1'b0, 3'd0, 4'h0, 1'b1, 3'd7, 4'h3, 1'b0, 3'd7, 3'd7, 16'h0003, 16'h0003, 1'b0, 1'b0};
      vt[8]  = '{1'b1, 3'd0, 4'h8, 1'b1, 3'd0, 4'h1, 1'b1, 3'd0, 3'd3, 16'h0001, 16'hFFFA, 1'b1, 1'b0};
      vt[9]  = '{1'b1, 3'd1, 4'h8, 1'b0, 3'd0, 4'h0, 1'b1, 3'd1, 3'd0, 16'hFFF8, 16'h0001, 1'b0, 1'b0};
      vt[10] = '{1'b0, 3'd2, 4'hF, 1'b0, 3'd0, 4'h0, 1'b1, 3'd2, 3'd5, 16'h0006, 16'h0007, 1'b0, 1'b0};
      vt[11] = '{1'b1, 3'd3, 4'h0, 1'b1, 3'd4, 4'hF, 1'b1, 3'd4, 3'd3, 16'hFFFF, 16'h0000, 1'b0, 1'b0};

      set_in(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 3'd0);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         z.tag = "por"; z.inst = i; z.en = 4'hF; z.ra = '0; z.rb = '0; z.c = 1'b0; z.e = 1'b0;
         check_inst(z);
      end
      rst = 1'b0;

      // fill with 5, read back, then reset asynchronously between edges
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 3'(i), 4'h5, 1'b1, 3'(i + 4), 4'h5, 1'b0, 3'd0, 3'd0);
         tick();
      end
      set_in(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 3'd5);
      for (int i = 0; i < 3; i++) expect_out("fill5", i, 4'hF, 16'h0005, 16'h0005, 1'b0, 1'b0);
      tick();
      #3 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         z.tag = "async_rst"; z.inst = i; z.en = 4'hF; z.ra = '0; z.rb = '0; z.c = 1'b0; z.e = 1'b0;
         check_inst(z);
      end
      set_in(1'b1, 3'd0, 4'hF, 1'b1, 3'd1, 4'hF, 1'b0, 3'd0, 3'd1);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         set_in(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 3'(i), 3'(7 - i));
         expect_out("cleared", 0, 4'hF, 16'h0000, 16'h0000, 1'b0, 1'b0);
         expect_out("cleared", 1, 4'hF, 16'h0000, 16'h0000, 1'b0, 1'b0);
         tick();
      end

      for (int k = 0; k < 12; k++) begin
         set_in(vt[k].we_a, vt[k].waddr_a, vt[k].wdata_a, vt[k].we_b, vt[k].waddr_b,
                vt[k].wdata_b, vt[k].sext, vt[k].raddr_a, vt[k].raddr_b);
         expect_out($sformatf("vec%0d", k), 0, 4'hF, vt[k].ea, vt[k].eb, vt[k].ec, vt[k].ee);
         tick();
      end

      // load R0..R7 with 0..7; the 6-entry instance flags the writes to 6 and 7
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 3'(i), 4'(i), 1'b1, 3'(i + 4), 4'(i + 4), 1'b0, 3'd0, 3'd0);
         expect_out("load", 0, 4'b0011, 16'h0, 16'h0, 1'b0, 1'b0);
         expect_out("load", 2, 4'b0001, 16'h0, 16'h0, 1'b0, (i >= 2));
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         set_in(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 3'(i), 3'(7 - i));
         expect_out("sweep", 0, 4'hF, 16'(i), 16'(7 - i), 1'b0, 1'b0);
         expect_out("sweep", 1, 4'hF, 16'(i), 16'(7 - i), 1'b0, 1'b0);
         tick();
      end

      // write-first versus read-first on R7
      set_in(1'b1, 3'd7, 4'h9, 1'b0, 3'd0, 4'h0, 1'b0, 3'd7, 3'd0);
      expect_out("byp0", 0, 4'b1000, 16'h0009, 16'h0, 1'b0, 1'b0);
      expect_out("byp0", 1, 4'b1000, 16'h0007, 16'h0, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 3'd7, 4'h3, 1'b0, 3'd0, 4'h0, 1'b0, 3'd7, 3'd0);
      expect_out("byp1", 0, 4'b1000, 16'h0003, 16'h0, 1'b0, 1'b0);
      expect_out("byp1", 1, 4'b1000, 16'h0009, 16'h0, 1'b0, 1'b0);
      tick();
      set_in(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd7, 3'd0);
      expect_out("byp2", 0, 4'b1000, 16'h0003, 16'h0, 1'b0, 1'b0);
      expect_out("byp2", 1, 4'b1000, 16'h0003, 16'h0, 1'b0, 1'b0);
      tick();

      // out-of-range accesses on the 6-entry instance
      set_in(1'b1, 3'd6, 4'hF, 1'b0, 3'd0, 4'h0, 1'b0, 3'd5, 3'd0);
      expect_out("oor_wr", 2, 4'hF, 16'h0005, 16'h0000, 1'b0, 1'b1);
      tick();
      set_in(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd7, 3'd4);
      expect_out("oor_rd", 2, 4'hF, 16'h0000, 16'h0004, 1'b0, 1'b1);
      tick();
      set_in(1'b1, 3'd7, 4'h1, 1'b1, 3'd7, 4'h2, 1'b0, 3'd5, 3'd1);
      expect_out("oor_coll", 2, 4'hF, 16'h0005, 16'h0001, 1'b0, 1'b1);
      expect_out("oor_coll", 0, 4'b0011, 16'h0, 16'h0, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 6; i++) begin
         set_in(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 3'(i), 3'(5 - i));
         expect_out("oor_keep", 2, 4'hF, 16'(i), 16'(5 - i), 1'b0, 1'b0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_dp.md
# regfile_dp

Parametrised two-write, two-read register file; successor to the 4×8-bit lab register file. It holds `NREGS` registers of `DATA_W` bits and accepts narrow write data sign- or zero-extended to full width. It supports two independent write ports with a defined collision priority and provides registered read ports with selectable write-first bypass. It sits between the switch/datapath front end and the HEX display or ALU operand paths.

## Interface
- `DATA_W`, 16, register width in bits (≥ 2)
- `IN_W`, 4, write-data input width (1 ≤ `IN_W` ≤ `DATA_W`)
- `NREGS`, 8, number of registers (2..256; need not be a power of 2)
- `ADDR_W`, `$clog2(NREGS)`, address width
- `BYPASS`, 1: write-first reads; 0: read-first reads

- `clk`  in  1  single clock; everything samples on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `we_a`  in  1  write enable, port A
- `waddr_a`  in  `ADDR_W`  write address, port A
- `wdata_a`  in  `IN_W`  write data, port A
- `we_b`  in  1  write enable, port B
- `waddr_b`  in  `ADDR_W`  write address, port B
- `wdata_b`  in  `IN_W`  write data, port B
- `sext`  in  1  1: sign-extend write data to `DATA_W`; 0: zero-extend (applies to both ports)
- `raddr_a`, `raddr_b`  in  `ADDR_W`  read addresses
- `rdata_a`, `rdata_b`  out  `DATA_W`  registered read data
- `collision`  out  1  registered pulse: both ports wrote the same address in the previous cycle
- `addr_err`  out  1  registered pulse: any enabled write or any read used an address ≥ `NREGS` in the previous cycle

## Operation
- Extension: `ext(d) = sext ? {{(DATA_W-IN_W){d[IN_W-1]}}, d} : {{(DATA_W-IN_W){1'b0}}, d}`. When `IN_W == DATA_W`, there is no extension.
- Write: on each edge, `R[waddr_a] <= ext(wdata_a)` if `we_a` is set and the address is in range. Port B writes the same way.
- Collision: if both ports are enabled with equal, in-range addresses, port B wins. `collision` is 1 for the next cycle. Writes to different addresses both commit.
- Out-of-range write: ignored and registers are unchanged. `addr_err` is 1 for the next cycle.
- Read: on each edge, `rdata_x <= value(raddr_x)`.
  - `BYPASS=1`: the value includes writes committing on the same edge, with port B priority.
  - `BYPASS=0`: the value is the pre-edge register contents.
- Out-of-range read: `rdata_x <= 0` and `addr_err` is 1 for the next cycle.
- No write enable asserted: all registers hold.
- There is no other state and no state machine. The registers, the two read registers and the two flag registers are the only sequential elements.

## Timing
- Reset (asynchronous, immediate on `rst` high): every register R0..R(NREGS-1) = 0, `rdata_a` = `rdata_b` = 0, `collision` = 0, `addr_err` = 0. Held until the first rising edge with `rst` low.
- Reset mid-write: a write whose edge coincides with `rst` high is lost.
- Write latency: data is visible in the register at edge k+1.
- Read latency: an address presented before edge k gives `rdata` valid after edge k, a fixed 1 cycle.
- Write then read of the same register:
  - `BYPASS=1`: the new value appears on `rdata` after the same edge k.
  - `BYPASS=0`: the new value appears after edge k+1.
- `collision` and `addr_err` are single-cycle pulses aligned with the `rdata` update of the offending edge. They reassert every cycle the condition repeats.
- No handshake: every port is accepted every cycle with no backpressure.

## Test plan
- Reset/clear: write 0x5 to all 8 registers, pulse `rst` asynchronously between edges.
  - All `rdata` = 0x0000 and flags = 0 immediately.
  - Reading R0..R7 afterwards returns 0x0000.
- Extension (`DATA_W`=16, `IN_W`=4):
  - `sext`=1, write 4'hA to R3: read R3 = 0xFFFA.
  - `sext`=0, write 4'hA to R4: read R4 = 0x000A.
  - `sext`=1, write 4'h7 to R5: read R5 = 0x0007.
- Collision: `we_a`=`we_b`=1, both addresses = 2, `wdata_a`=4'h1, `wdata_b`=4'h6, `sext`=0.
  - R2 = 0x0006 and `collision` = 1 for exactly one cycle.
  - Same stimulus with addresses 1 and 6: R1 = 0x0001, R6 = 0x0006, `collision` = 0.
- Bypass: write 0x3 to R7 while `raddr_a`=7 holds the old value 0x0009.
  - `BYPASS=1`: `rdata_a` = 0x0003 after the same edge.
  - `BYPASS=0`: `rdata_a` = 0x0009, then 0x0003 one cycle later.
- Out of range (`NREGS`=6, `ADDR_W`=3): write to address 6, then read address 7.
  - All registers unchanged, `rdata_a` = 0, and `addr_err` pulses for each offending cycle.
- Dual-read sweep: load R0..R7 with 0..7, `raddr_a` counts up while `raddr_b` counts down.
  - Each cycle `rdata_a` = previous `raddr_a` and `rdata_b` = previous `raddr_b`, both 1-cycle latency.
